sc_road_sequencer: RTL
======================

Name: sc_road_sequencer

Overview:
- Game-flow controller for the RoadFighter road display.
- Sequences the per-row mux-select datapath through idle, preload, play, crash and game-over phases.
- Owns level (speed) progression and lives.
- Sits between the start button, frame-tick prescaler and collision detector on one side and the row register/mux bank on the other.

Parameters:
SELECT_WIDTH, 2, width of each row select code
ROWS, 8, number of display rows driven
LEVEL_WIDTH, 3, width of level counter
LIVES_WIDTH, 2, width of lives counter
LIVES_INIT, 3, lives loaded on game start
TICKS_PER_LEVEL, 16, PLAY ticks per level increment
CRASH_TICKS, 4, ticks spent in CRASH

Ports:
SC_ROADSEQ_CLOCK_50  in  1  system clock, all state on rising edge
SC_ROADSEQ_RESET_InLow  in  1  asynchronous active-low reset
SC_ROADSEQ_START_InLow  in  1  start button, active low, already debounced
SC_ROADSEQ_TICK_InHigh  in  1  one-cycle frame tick from prescaler
SC_ROADSEQ_COLLISION_InHigh  in  1  collision flag from detector, level
SC_ROADSEQ_SELECT_OUT  out  ROWS*SELECT_WIDTH  packed row selects, row0 in LSBs
SC_ROADSEQ_LEVEL_OUT  out  LEVEL_WIDTH  current level, drives prescaler rate
SC_ROADSEQ_LIVES_OUT  out  LIVES_WIDTH  remaining lives
SC_ROADSEQ_STATE_OUT  out  3  state code
SC_ROADSEQ_GAMEOVER_OUT  out  1  high while in GAMEOVER

Behaviour:
- Interface decision: one clock, SC_ROADSEQ_CLOCK_50. Reset SC_ROADSEQ_RESET_InLow is asynchronous and active-low.
- Select codes:
  - 0 CLEAR: rows zeroed.
  - 1 HOLD.
  - 2 SHIFT: row n loads row n-1; row0 loads random.
  - 3 PRELOAD: initial pattern.
  - All ROWS fields always carry the same code.
- Start event: one-cycle pulse on a falling edge of START_InLow.
  - Detected with a registered previous-value flop, reset to 1.
  - Holding the button low produces exactly one event.
- Reset (async, any state): state=IDLE, selects=0, level=0, lives=LIVES_INIT, tick and crash counters=0, GAMEOVER_OUT=0, start flop=1.
- Outputs are registered.
  - SELECT_OUT, STATE_OUT and GAMEOVER_OUT reflect the current state.
  - In PLAY, SELECT_OUT is additionally qualified by the registered tick, giving one cycle latency from TICK_InHigh.
- States (code):
  - IDLE (0):
    - selects=0.
    - lives=LIVES_INIT, level=0, counters cleared.
    - Start event -> PRELOAD.
  - PRELOAD (1):
    - selects=3 for exactly one clock.
    - Tick counter cleared.
    - -> PLAY unconditionally.
  - PLAY (2):
    - selects=2 in the cycle after a tick, else 1.
    - Each tick increments the tick counter.
    - When the tick counter reaches TICKS_PER_LEVEL-1 on a tick: counter wraps to 0, level increments, saturating at 2^LEVEL_WIDTH-1.
    - COLLISION_InHigh=1 on any cycle -> CRASH, lives decrements, crash counter=0.
    - Start event ignored (unless PAUSE_EN is defined).
  - CRASH (3):
    - selects=1.
    - Collision ignored.
    - Each tick increments the crash counter.
    - On the tick where the counter reaches CRASH_TICKS-1: if lives==0 -> GAMEOVER, else -> PRELOAD.
    - Level is retained across a crash.
  - GAMEOVER (4):
    - selects=1 (display frozen), GAMEOVER_OUT=1.
    - Start event -> IDLE.
- Simultaneous events:
  - Collision and level-up tick in the same cycle: collision wins; level and tick counter unchanged.
  - Collision and tick in the same cycle in PLAY: no SHIFT is issued.
- Lives never underflow: decrement happens only on PLAY->CRASH. Lives>=1 is guaranteed in PLAY.
- Illegal state codes 5-7 -> IDLE on the next clock.

Optional Feature:
- Macro SC_ROADSEQ_PAUSE_EN.
- When defined:
  - Adds state PAUSE (5): selects=1.
  - Tick and crash counters frozen; collision ignored.
  - Start event in PLAY -> PAUSE; start event in PAUSE -> PLAY.
  - Level and tick counter are preserved across the pause.
- When undefined:
  - No PAUSE state; code 5 is illegal and returns to IDLE.
  - Start event in PLAY is ignored.

Test Plan:
- Reset mid-PLAY, level=2, lives=1 -> same cycle: STATE_OUT=0, SELECT_OUT=16'h0000, LEVEL_OUT=0, LIVES_OUT=3.
- Start falling edge held low 100 cycles from IDLE -> one cycle SELECT_OUT=16'hFFFF, then STATE_OUT=2; no second PRELOAD.
- PLAY with 16 ticks -> each tick is followed one cycle later by SELECT_OUT=16'hAAAA, else 16'h5555. After the 16th tick, LEVEL_OUT=1. After 112 further ticks, LEVEL_OUT stays 7.
- Collision in PLAY with lives=3 -> STATE_OUT=3, LIVES_OUT=2. After 4 ticks, PRELOAD then PLAY, level unchanged. Third crash -> after 4 ticks, STATE_OUT=4, GAMEOVER_OUT=1. Start event -> IDLE, LIVES_OUT=3.
- Collision coincident with the 16th level tick -> LEVEL_OUT unchanged, STATE_OUT=3, no 16'hAAAA cycle.
- With SC_ROADSEQ_PAUSE_EN: start event in PLAY -> STATE_OUT=5, 10 ticks and a collision ignored. Start event -> PLAY with tick counter and lives unchanged. Without the macro, the same stimulus keeps STATE_OUT=2.

Source files
------------

// File: rtl/sc_road_sequencer.sv
// ============================================================================
// Module   : sc_road_sequencer
// Purpose  : RoadFighter game-flow controller: row-select sequencing, level
//            progression and lives. Optional PAUSE state via SC_ROADSEQ_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_road_sequencer #(
  parameter int SELECT_WIDTH    = 2,
  parameter int ROWS            = 8,
  parameter int LEVEL_WIDTH     = 3,
  parameter int LIVES_WIDTH     = 2,
  parameter int LIVES_INIT      = 3,
  parameter int TICKS_PER_LEVEL = 16,
  parameter int CRASH_TICKS     = 4
) (
  input  logic                         SC_ROADSEQ_CLOCK_50,
  input  logic                         SC_ROADSEQ_RESET_InLow,
  input  logic                         SC_ROADSEQ_START_InLow,
  input  logic                         SC_ROADSEQ_TICK_InHigh,
  input  logic                         SC_ROADSEQ_COLLISION_InHigh,
  output logic [ROWS*SELECT_WIDTH-1:0] SC_ROADSEQ_SELECT_OUT,
  output logic [LEVEL_WIDTH-1:0]       SC_ROADSEQ_LEVEL_OUT,
  output logic [LIVES_WIDTH-1:0]       SC_ROADSEQ_LIVES_OUT,
  output logic [2:0]                   SC_ROADSEQ_STATE_OUT,
  output logic                         SC_ROADSEQ_GAMEOVER_OUT
);

  localparam int c_tick_w  = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam int c_crash_w = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;

  localparam logic [c_tick_w-1:0]     c_tick_last  = c_tick_w'(TICKS_PER_LEVEL - 1);
  localparam logic [c_crash_w-1:0]    c_crash_last = c_crash_w'(CRASH_TICKS - 1);
  localparam logic [LEVEL_WIDTH-1:0]  c_level_max  = {LEVEL_WIDTH{1'b1}};
  localparam logic [LIVES_WIDTH-1:0]  c_lives_init = LIVES_WIDTH'(LIVES_INIT);

  localparam logic [SELECT_WIDTH-1:0] c_sel_clear   = SELECT_WIDTH'(0);
  localparam logic [SELECT_WIDTH-1:0] c_sel_hold    = SELECT_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] c_sel_shift   = SELECT_WIDTH'(2);
  localparam logic [SELECT_WIDTH-1:0] c_sel_preload = SELECT_WIDTH'(3);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRELOAD  = 3'd1,
    ST_PLAY     = 3'd2,
    ST_CRASH    = 3'd3,
    ST_GAMEOVER = 3'd4
`ifdef SC_ROADSEQ_PAUSE_EN
    ,ST_PAUSE   = 3'd5
`endif
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_start_prev;
  logic [c_tick_w-1:0]     r_tick_cnt, w_tick_cnt;
  logic [c_crash_w-1:0]    r_crash_cnt, w_crash_cnt;
  logic [LEVEL_WIDTH-1:0]  r_level, w_level;
  logic [LIVES_WIDTH-1:0]  r_lives, w_lives;
  logic [SELECT_WIDTH-1:0] r_sel, w_sel;
  logic                    r_gameover;
  logic                    w_shift;
  logic                    w_start_evt;

  // Falling edge of the (active-low) start button
  assign w_start_evt = r_start_prev & ~SC_ROADSEQ_START_InLow;

  always_comb begin
    w_next      = r_state;
    w_tick_cnt  = r_tick_cnt;
    w_crash_cnt = r_crash_cnt;
    w_level     = r_level;
    w_lives     = r_lives;
    w_shift     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_evt) w_next = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        w_tick_cnt = '0;
        w_next     = ST_PLAY;
      end
      ST_PLAY: begin
        // Collision outranks both the tick (no shift, no level-up) and start
        if (SC_ROADSEQ_COLLISION_InHigh) begin
          w_next      = ST_CRASH;
          w_lives     = r_lives - LIVES_WIDTH'(1);
          w_crash_cnt = '0;
        end
`ifdef SC_ROADSEQ_PAUSE_EN
        else if (w_start_evt) begin
          w_next = ST_PAUSE;
        end
`endif
        else if (SC_ROADSEQ_TICK_InHigh) begin
          w_shift = 1'b1;
          if (r_tick_cnt == c_tick_last) begin
            w_tick_cnt = '0;
            if (r_level != c_level_max) w_level = r_level + LEVEL_WIDTH'(1);
          end else begin
            w_tick_cnt = r_tick_cnt + c_tick_w'(1);
          end
        end
      end
      ST_CRASH: begin
        if (SC_ROADSEQ_TICK_InHigh) begin
          if (r_crash_cnt == c_crash_last) begin
            w_crash_cnt = '0;
            w_next      = (r_lives == '0) ? ST_GAMEOVER : ST_PRELOAD;
          end else begin
            w_crash_cnt = r_crash_cnt + c_crash_w'(1);
          end
        end
      end
      ST_GAMEOVER: begin
        if (w_start_evt) w_next = ST_IDLE;
      end
`ifdef SC_ROADSEQ_PAUSE_EN
      ST_PAUSE: begin
        if (w_start_evt) w_next = ST_PLAY;
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Entering or sitting in IDLE re-arms a fresh game
    if (w_next == ST_IDLE) begin
      w_tick_cnt  = '0;
      w_crash_cnt = '0;
      w_level     = '0;
      w_lives     = c_lives_init;
    end
  end

  // Select code is registered alongside the state so both update together
  always_comb begin
    w_sel = c_sel_clear;
    case (w_next)
      ST_PRELOAD:  w_sel = c_sel_preload;
      ST_PLAY:     w_sel = w_shift ? c_sel_shift : c_sel_hold;
      ST_CRASH:    w_sel = c_sel_hold;
      ST_GAMEOVER: w_sel = c_sel_hold;
`ifdef SC_ROADSEQ_PAUSE_EN
      ST_PAUSE:    w_sel = c_sel_hold;
`endif
      default:     w_sel = c_sel_clear;
    endcase
  end

  always_ff @(posedge SC_ROADSEQ_CLOCK_50 or negedge SC_ROADSEQ_RESET_InLow) begin
    if (!SC_ROADSEQ_RESET_InLow) begin
      r_state      <= ST_IDLE;
      r_start_prev <= 1'b1;
      r_tick_cnt   <= '0;
      r_crash_cnt  <= '0;
      r_level      <= '0;
      r_lives      <= c_lives_init;
      r_sel        <= c_sel_clear;
      r_gameover   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_start_prev <= SC_ROADSEQ_START_InLow;
      r_tick_cnt   <= w_tick_cnt;
      r_crash_cnt  <= w_crash_cnt;
      r_level      <= w_level;
      r_lives      <= w_lives;
      r_sel        <= w_sel;
      r_gameover   <= (w_next == ST_GAMEOVER);
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_rows
    assign SC_ROADSEQ_SELECT_OUT[g*SELECT_WIDTH +: SELECT_WIDTH] = r_sel;
  end

  assign SC_ROADSEQ_LEVEL_OUT    = r_level;
  assign SC_ROADSEQ_LIVES_OUT    = r_lives;
  assign SC_ROADSEQ_STATE_OUT    = r_state;
  assign SC_ROADSEQ_GAMEOVER_OUT = r_gameover;

endmodule

`default_nettype wire
